// File: rtl/hqc_sampler_pkg.sv
// Shared constants and types for the HQC fixed-weight sampler (HQC-128 parameter set).
package hqc_sampler_pkg;

    localparam int N      = 17669;
    localparam int M      = 15;
    localparam int TAU    = 75;
    localparam int LOGTAU = 7;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    typedef logic [15:0]       cand_t;
    typedef logic [M-1:0]      loc_t;
    typedef logic [LOGTAU-1:0] addr_t;

    localparam loc_t  N_LOC    = loc_t'(N);
    localparam cand_t CAND_MSK = cand_t'((1 << M) - 1);

    // Keep only the low M bits of a raw 16-bit candidate.
    function automatic loc_t mask_cand(input cand_t c);
        return loc_t'(c & CAND_MSK);
    endfunction

    function automatic logic loc_in_range(input loc_t v);
        return v < N_LOC;
    endfunction

endpackage

// File: rtl/rand_word_unpacker.sv
// Two-entry candidate buffer: splits each accepted 32-bit random word into
// two 16-bit candidates (low half first) and presents them one per cycle.
module rand_word_unpacker
    import hqc_sampler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        block,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] rand_data,
    input  logic        rand_valid,
    output logic        rand_ready,
    output cand_t       head,
    output logic        head_valid
);

    cand_t       half [2];
    cand_t       slot_q [2];
    cand_t       slot_d [2];
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        push;

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign half[gi] = rand_data[16*gi +: 16];
    end

    // Accepting a word at count 1 is safe: the head is popped the same cycle.
    assign rand_ready = active && !block && (count_q != 2'd2);
    assign push       = rand_valid && rand_ready;
    assign head       = slot_q[0];
    assign head_valid = (count_q != 2'd0);

    always_comb begin
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        count_d   = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push) begin
            slot_d[0] = half[0];
            slot_d[1] = half[1];
            count_d   = 2'd2;
        end else if (pop && head_valid) begin
            slot_d[0] = slot_q[1];
            count_d   = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            count_q   <= 2'd0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/fixed_weight_sampler.sv
// Rejection sampler filling TAU location slots (or refilling one) from 32-bit random words.
// Optional SAMPLER_STATS_EN adds a saturating reject_count output.
module fixed_weight_sampler
    import hqc_sampler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              refill,
    input  logic [LOGTAU-1:0] refill_addr,
    input  logic [31:0]       rand_data,
    input  logic              rand_valid,
    output logic              rand_ready,
    output logic [LOGTAU-1:0] wr_addr,
    output logic [M-1:0]      wr_data,
    output logic              wr_en,
    output logic              busy,
`ifdef SAMPLER_STATS_EN
    output logic [15:0]       reject_count,
`endif
    output logic              done
);

    state_t state_q, state_d;
    addr_t  target_q, target_d;
    addr_t  ptr_q, ptr_d;
    addr_t  acc_q, acc_d;
    logic   wr_en_q, wr_en_d;
    addr_t  wr_addr_q, wr_addr_d;
    loc_t   wr_data_q, wr_data_d;
    logic   last_q, last_d;
    logic   done_q, done_d;

    cand_t  head;
    logic   head_valid;
    loc_t   cand_loc;
    logic   running;
    logic   eval;
    logic   accept;
    logic   reject;
    logic   final_accept;

    // The last write and done trail the final accept, so stop sampling early.
    assign running      = (state_q == FILL) && !last_q && !done_q;
    assign cand_loc     = mask_cand(head);
    assign eval         = running && head_valid;
    assign accept       = eval && loc_in_range(cand_loc);
    assign reject       = eval && !loc_in_range(cand_loc);
    assign final_accept = accept && ((acc_q + addr_t'(1)) == target_q);

    rand_word_unpacker u_unpacker (
        .clk        (clk),
        .rst        (rst),
        .active     (running),
        .block      (final_accept),
        .pop        (eval),
        .flush      (final_accept),
        .rand_data  (rand_data),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .head       (head),
        .head_valid (head_valid)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        last_d    = 1'b0;
        done_d    = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FILL;
                    target_d = addr_t'(TAU);
                    ptr_d    = '0;
                    acc_d    = '0;
                end else if (refill) begin
                    state_d  = FILL;
                    target_d = addr_t'(1);
                    ptr_d    = refill_addr;
                    acc_d    = '0;
                end
            end
            FILL: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = cand_loc;
                    acc_d     = acc_q + addr_t'(1);
                    // Hold the pointer on the last write so it stays inside the slot range.
                    if (final_accept) begin
                        last_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + addr_t'(1);
                    end
                end
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            ptr_q     <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign busy    = (state_q == FILL);

`ifdef SAMPLER_STATS_EN
    logic [15:0] reject_cnt_q, reject_cnt_d;

    always_comb begin
        reject_cnt_d = reject_cnt_q;
        if (state_q == IDLE && (start || refill)) begin
            reject_cnt_d = '0;
        end else if (reject && reject_cnt_q != 16'hFFFF) begin
            reject_cnt_d = reject_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reject_cnt_q <= '0;
        end else begin
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign reject_count = reject_cnt_q;
`else
    logic unused_reject;
    assign unused_reject = reject;
`endif

endmodule

// File: doc/fixed_weight_sampler.md
# fixed_weight_sampler

Rejection-sampling front end that turns a stream of 32-bit random words (from the SHAKE/PRNG stage) into TAU distinct-slot error locations in `[0, N)` and writes them into the dual-port location memory. Sits directly upstream of `duplicate_detection`: it fills the memory that stage reads, then services per-slot refill requests when a collision is found.

## Interface
- `N`, 17669, code length; exclusive upper bound for accepted locations
- `M`, 15, location width in bits (`2^M >= N`)
- `TAU`, 75, number of locations per fill
- `LOGTAU`, 7, address width (`2^LOGTAU >= TAU`)
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — pulse; begin full fill of slots 0..TAU-1
- `refill` in 1 — pulse; replace one slot with a fresh location
- `refill_addr` in LOGTAU — slot to replace, sampled with `refill`
- `rand_data` in 32 — random word
- `rand_valid` in 1 — `rand_data` valid
- `rand_ready` out 1 — word consumed when `rand_valid && rand_ready`
- `wr_addr` out LOGTAU — location memory write address
- `wr_data` out M — location value
- `wr_en` out 1 — write strobe, one cycle per accepted location
- `busy` out 1 — high in FILL
- `done` out 1 — one-cycle pulse when the requested fill/refill completes

## Operation
- States: IDLE, FILL. Reset → IDLE.
- IDLE + `start` → FILL, target = TAU, write pointer = 0. IDLE + `refill` → FILL, target = 1, write pointer = `refill_addr`. `start` and `refill` same cycle: `start` wins. Both ignored in FILL.
- Captured word splits into two candidates: low half `rand_data[15:0]` first, then `rand_data[31:16]`; each masked to low M bits.
- Candidate accepted iff masked value < N (strict). Accepted: `wr_en=1`, `wr_data=value`, `wr_addr=pointer`; pointer increments, accepted count increments. Rejected: no write, no pointer change.
- When accepted count reaches target: remaining buffered candidate discarded, `done` pulses, state → IDLE, `rand_ready` drops the same cycle.
- No uniqueness checking here; duplicates are resolved by `duplicate_detection` issuing `refill`.
- `rand_valid` low stalls evaluation only after buffer drains; no internal timeout.

## Timing
- Reset values: `rand_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `done=0`; buffer count 0, pointer 0, accepted count 0.
- Two-entry candidate buffer (count 0/1/2); one candidate evaluated per cycle.
- `rand_ready = FILL && (count==0 || count==1) && not final accept this cycle`. A word captured with count==1 refills behind the candidate being evaluated → sustained 1 word per 2 cycles.
- Capture at edge t → low half evaluated in cycle t+1, write registered at edge t+2 (`wr_en` high in cycle t+2); high half one cycle later.
- `done` asserts in the cycle after the last `wr_en` edge, i.e. final write and `done` are never in the same cycle; memory holds final data when `done` is seen.
- `busy` high from the cycle after `start`/`refill` through the cycle `done` is high; low afterwards.
- Pointer never exceeds TAU-1 on a full fill; `refill_addr >= TAU` is an illegal input (no check).
- `rst` mid-fill: next edge returns all state to reset values; partial memory contents untouched; no `done`.

## Configuration
- `SAMPLER_STATS_EN` defined: adds output `reject_count` (16 bits), cleared on `start`/`refill`/`rst`, +1 per rejected candidate, saturating at 0xFFFF; held after `done`.
- Undefined: port and counter absent; functional behaviour identical.

## Structure
- Shared package `hqc_sampler_pkg`: N, M, TAU, LOGTAU constants per parameter set, state enum {IDLE, FILL}, 16-bit candidate type.
- Sub-module `rand_word_unpacker`: the two-entry candidate buffer with `rand_ready` logic and count; parent owns FSM, compare, pointer and write port.

## Test plan
- Reset then `start`, feed words with both halves < 17669 → exactly 75 `wr_en` pulses at addresses 0..74, `done` one cycle after last write, `busy` low after.
- Word 0x4504_4505 → low half 17669 rejected, high half 17668 written; with stats `reject_count=1`.
- Word 0xC504_FFFF → 0x7FFF rejected, 0xC504 masked to 17668 accepted.
- Fill with 74 accepts, then word 0x0001_0002 → only 2 written at addr 74, 1 discarded, `rand_ready` low same cycle.
- `refill` with `refill_addr=33`, words 0x7FFF_7FFF then 0x0000_0100 → single write data 256 at addr 33, `done` pulse; `start` during this ignored.
- `rst` asserted at 40th accept → next cycle all outputs zero, no `done`; fresh `start` writes from address 0.
